wm_pixel_writeback: RTL
=======================

Name: wm_pixel_writeback

Overview:
- Downstream neighbour of the watermarking controller.
- Consumes the modified-pixel stream (Pixel_Data / new_pixel), which the block divider emits block by block in row-major order within each M x M block.
- Computes each pixel's raster-order address in the output image and issues one write per pixel to the output image buffer.
- Raises a block-done pulse per completed block and an image-done level when all (Np/M)^2 blocks are written.

Parameters:
Data_Depth, 8, pixel bit depth
Amba_Addr_Depth, 20, address width minus 1 (addresses are Amba_Addr_Depth+1 bits)
Block_Depth, 7, width of in-block row/col counters (M <= 72)
Img_Depth, 10, width of Np (image side, max 720)
Out_Base, 0, output-buffer address of raster pixel (0,0)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latches Np and M, begins a new image
Np  in  Img_Depth  primary image side in pixels
M  in  Data_Depth  block side in pixels
Pixel_Data  in  Data_Depth  modified pixel from block divider
new_pixel  in  1  Pixel_Data valid this cycle
wr_en  out  1  output-buffer write strobe
wr_addr  out  Amba_Addr_Depth+1  output-buffer write address
wr_data  out  Data_Depth  output-buffer write data
block_done  out  1  one-cycle pulse, last pixel of a block written
image_done  out  1  level, high from last write until next start/reset
err  out  1  sticky: bad parameters or pixel received outside RUN

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; all counters and address registers 0.
- States:
  - IDLE: wait for start.
  - CALC: on start, latch Np and M. If M==0 or M>Np, set err and go to DONE. Otherwise derive by sequential arithmetic (no combinational divide/multiply):
    - bpr = Np/M by repeated subtraction; a nonzero remainder sets err and goes to DONE.
    - NpM = Np*M by M additions of Np.
    - CALC length is data-dependent, at most bpr+M+2 cycles.
  - RUN: accept pixels.
  - DONE: image_done=1. Hold until start.
- Address registers:
  - blkrow_base: start of current block row.
  - blk_base: top-left of current block.
  - row_base: start of current row within the block.
  - addr: next write address.
  - All initialise to Out_Base on entry to RUN; col, row, blk_col, blk_row initialise to 0.
- Per new_pixel in RUN (one-cycle latency): next cycle wr_en=1, wr_addr=addr, wr_data=the Pixel_Data sampled. Back-to-back new_pixel sustains one write per cycle. Counter update in the same edge:
  - col+1<M: col++, addr++.
  - else if row+1<M: col=0, row++, row_base+=Np, addr=row_base+Np.
  - else (block end): col=row=0; block_done pulses with the final write.
    - If blk_col+1<bpr: blk_col++, blk_base+=M.
    - Else: blk_col=0, blk_row++, blkrow_base+=NpM, blk_base=blkrow_base+NpM.
    - addr and row_base take the new blk_base.
    - If blk_row+1==bpr: go to DONE; image_done rises together with the final wr_en.
- All address arithmetic is Amba_Addr_Depth+1 bits unsigned. No wrap within a legal image (720*720+Out_Base fits).
- new_pixel in IDLE, CALC or DONE: ignored (no write) and err set.
- start in any state: abort the current image, clear image_done and err, re-enter CALC. A pixel write scheduled in that cycle is still issued.
- start and new_pixel in the same cycle: start wins; the pixel is ignored without setting err.
- wr_en, block_done, image_done and err are glitch-free registered outputs.

Test Plan:
1. Np=4, M=2, Out_Base=0, start, then 16 back-to-back pixels valued 0..15 -> wr_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15 with wr_data=0..15; block_done after writes 4,8,12,16; image_done rises with write 16.
2. Np=6, M=3, pixels sent with a 1-idle-cycle gap -> 36 writes; block 1 addresses 3,4,5,9,10,11,15,16,17; writes appear only on cycles following new_pixel.
3. Np=5, M=2 -> err=1, DONE entered from CALC, no writes; new_pixel afterwards causes no wr_en.
4. Np=4, M=2; assert rst after 5 pixels -> all outputs 0 immediately (asynchronous). Then start and 16 pixels -> sequence identical to scenario 1.
5. Np=4, M=4 (single block) -> addresses 0..15 in order; block_done and image_done on the 16th write.
6. new_pixel pulsed in IDLE -> err=1, no wr_en. Subsequent start clears err; normal run follows.

Source files
------------

// File: rtl/wm_pixel_writeback_if.sv
// Pixel-in / buffer-write bundle for the watermark pixel writeback stage.
// The slave side is the writeback block; the master side feeds it pixels.
interface wm_pixel_writeback_if #(
  parameter int Data_Depth      = 8,
  parameter int Amba_Addr_Depth = 20,
  parameter int Img_Depth       = 10
);
  logic                   start;
  logic [Img_Depth-1:0]   Np;
  logic [Data_Depth-1:0]  M;
  logic [Data_Depth-1:0]  Pixel_Data;
  logic                   new_pixel;
  logic                   wr_en;
  logic [Amba_Addr_Depth:0] wr_addr;
  logic [Data_Depth-1:0]  wr_data;
  logic                   block_done;
  logic                   image_done;
  logic                   err;

  modport master (
    output start, Np, M, Pixel_Data, new_pixel,
    input  wr_en, wr_addr, wr_data,
    input  block_done, image_done, err
  );

  modport slave (
    input  start, Np, M, Pixel_Data, new_pixel,
    output wr_en, wr_addr, wr_data,
    output block_done, image_done, err
  );
endinterface

// File: rtl/wm_pixel_writeback.sv
// Writes block-ordered modified pixels back to the output image
// buffer in raster order; derives Np/M and Np*M sequentially.
module wm_pixel_writeback #(
  parameter int Data_Depth      = 8,
  parameter int Amba_Addr_Depth = 20,
  parameter int Block_Depth     = 7,
  parameter int Img_Depth       = 10,
  parameter int Out_Base        = 0
) (
  input logic clk,
  input logic rst,
  wm_pixel_writeback_if.slave bus
);
  localparam int AW = Amba_Addr_Depth + 1;

  typedef enum logic [1:0] {
    IDLE, CALC, RUN, DONE
  } state_t;

  typedef enum logic [1:0] {
    C_CHK, C_DIV, C_MUL
  } phase_t;

  state_t state;
  phase_t phase;

  logic [AW-1:0] np_r, m_r, rem, npm;
  logic [Img_Depth-1:0] bpr;
  logic [Data_Depth-1:0] cnt;
  logic [AW-1:0] blkrow_base, blk_base;
  logic [AW-1:0] row_base, addr;
  logic [Block_Depth-1:0] col, row;
  logic [Img_Depth-1:0] blk_col, blk_row;

  logic [AW-1:0] col_n, row_n;
  logic [AW-1:0] bcol_n, brow_n;
  logic [AW-1:0] bpr_a, cnt_n;
  logic [AW-1:0] nxt_row, nxt_blk;
  logic [AW-1:0] nxt_brow;

  assign col_n    = AW'(col) + AW'(1);
  assign row_n    = AW'(row) + AW'(1);
  assign bcol_n   = AW'(blk_col) + AW'(1);
  assign brow_n   = AW'(blk_row) + AW'(1);
  assign bpr_a    = AW'(bpr);
  assign cnt_n    = AW'(cnt) + AW'(1);
  assign nxt_row  = row_base + np_r;
  assign nxt_blk  = blk_base + m_r;
  assign nxt_brow = blkrow_base + npm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= C_CHK;
      np_r           <= '0;
      m_r            <= '0;
      rem            <= '0;
      npm            <= '0;
      bpr            <= '0;
      cnt            <= '0;
      blkrow_base    <= '0;
      blk_base       <= '0;
      row_base       <= '0;
      addr           <= '0;
      col            <= '0;
      row            <= '0;
      blk_col        <= '0;
      blk_row        <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.block_done <= 1'b0;
      bus.image_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.block_done <= 1'b0;
      if (bus.start) begin
        np_r           <= AW'(bus.Np);
        m_r            <= AW'(bus.M);
        bus.err        <= 1'b0;
        bus.image_done <= 1'b0;
        phase          <= C_CHK;
        state          <= CALC;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.new_pixel) bus.err <= 1'b1;
          end
          CALC: begin
            if (bus.new_pixel) bus.err <= 1'b1;
            unique case (phase)
              C_CHK: begin
                if (m_r == '0 || m_r > np_r) begin
                  bus.err        <= 1'b1;
                  bus.image_done <= 1'b1;
                  state          <= DONE;
                end else begin
                  rem   <= np_r;
                  bpr   <= '0;
                  phase <= C_DIV;
                end
              end
              C_DIV: begin
                if (rem >= m_r) begin
                  rem <= rem - m_r;
                  bpr <= bpr + 1'b1;
                end else if (rem != '0) begin
                  bus.err        <= 1'b1;
                  bus.image_done <= 1'b1;
                  state          <= DONE;
                end else begin
                  npm   <= '0;
                  cnt   <= '0;
                  phase <= C_MUL;
                end
              end
              C_MUL: begin
                npm <= npm + np_r;
                cnt <= cnt + 1'b1;
                // last addition: arm the walk at the image origin
                if (cnt_n == m_r) begin
                  blkrow_base <= AW'(Out_Base);
                  blk_base    <= AW'(Out_Base);
                  row_base    <= AW'(Out_Base);
                  addr        <= AW'(Out_Base);
                  col         <= '0;
                  row         <= '0;
                  blk_col     <= '0;
                  blk_row     <= '0;
                  state       <= RUN;
                end
              end
              default: phase <= C_CHK;
            endcase
          end
          RUN: begin
            if (bus.new_pixel) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= addr;
              bus.wr_data <= bus.Pixel_Data;
              if (col_n < m_r) begin
                col  <= col + 1'b1;
                addr <= addr + AW'(1);
              end else if (row_n < m_r) begin
                col      <= '0;
                row      <= row + 1'b1;
                row_base <= nxt_row;
                addr     <= nxt_row;
              end else begin
                col            <= '0;
                row            <= '0;
                bus.block_done <= 1'b1;
                if (bcol_n < bpr_a) begin
                  blk_col  <= blk_col + 1'b1;
                  blk_base <= nxt_blk;
                  row_base <= nxt_blk;
                  addr     <= nxt_blk;
                end else begin
                  blk_col     <= '0;
                  blk_row     <= blk_row + 1'b1;
                  blkrow_base <= nxt_brow;
                  blk_base    <= nxt_brow;
                  row_base    <= nxt_brow;
                  addr        <= nxt_brow;
                  if (brow_n == bpr_a) begin
                    bus.image_done <= 1'b1;
                    state          <= DONE;
                  end
                end
              end
            end
          end
          DONE: begin
            if (bus.new_pixel) bus.err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
